// File: rtl/fpu_arb_pkg.sv
// Shared types and constants for the adder arbiter slice.
// Latency: none (declarations only).
// Backpressure: n/a.
package fpu_arb_pkg;

  localparam int ADDER_W  = 25;
  localparam int NREQ_MAX = 4;
  localparam int IDX_W    = $clog2(NREQ_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RESP    = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  // Round-robin successor of a requester index, wrapping at n.
  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx, input int n);
    if (int'(idx) >= n - 1) return '0;
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/fpu_adder_arbiter_rr_pick.sv
// rr_pick: round-robin selector, first set request at/after ptr (wrapping).
// Latency: combinational.
// Backpressure: none; caller decides when to act on the pick.
module rr_pick
  import fpu_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan priority slots ptr, ptr+1, ... and take the first active requester.
  always_comb begin
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int p = 0; p < N; p++) begin
        if (!found && req[p] && (p == ((int'(ptr) + k) % N))) begin
          found  = 1'b1;
          gnt[p] = 1'b1;
          idx    = IDX_W'(p);
        end
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/fpu_adder_arbiter.sv
// fpu_adder_arbiter: shares one adder between NREQ four-phase requesters, round-robin, one op in flight.
// Latency: Adder_valid rises one cycle after the grant edge; Req_ack one cycle after Adder_ack.
// Backpressure: requester holds Req_valid until Req_ack; optional abort watchdog via ADDER_ARB_TIMEOUT_EN.
module fpu_adder_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int WIDTH   = ADDER_W,
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       Req_valid,
  input  logic [NREQ*WIDTH-1:0] Req_datain1,
  input  logic [NREQ*WIDTH-1:0] Req_datain2,
  output logic [NREQ-1:0]       Req_ack,
  output logic [WIDTH-1:0]      Req_dataout,
  output logic                  Req_carryout,
  output logic [NREQ-1:0]       Grant,
  output logic                  Busy,
  output logic [WIDTH-1:0]      Adder_datain1,
  output logic [WIDTH-1:0]      Adder_datain2,
  output logic                  Adder_valid,
  input  logic [WIDTH-1:0]      Adder_dataout,
  input  logic                  Adder_carryout,
  input  logic                  Adder_ack,
  output logic                  Timeout_err
);

  arb_state_e       state_q, state_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0] gidx_q, gidx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             adv_q, adv_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cout_q, cout_d;

  logic [NREQ-1:0]  pick_gnt;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             owner_vld;
  logic             tmo_hit;

  rr_pick #(.N(NREQ)) u_rr_pick (
    .req (Req_valid),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // The granted requester still holds its request (no index arithmetic needed).
  assign owner_vld = |(Req_valid & grant_q);

`ifdef ADDER_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             terr_q, terr_d;
  logic             waiting;

  // Count cycles spent waiting for the adder's ACK edge; fire once the budget is used up.
  always_comb begin
    waiting = ((state_q == ISSUE) && !(Adder_ack && adv_q)) ||
              ((state_q == RELEASE) && Adder_ack);
    tmo_hit = waiting && (cnt_q == CNT_W'(TIMEOUT - 1));
    cnt_d   = (waiting && !tmo_hit) ? cnt_q + 1'b1 : '0;
    terr_d  = terr_q | tmo_hit;
  end

  // Watchdog counter and sticky error flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q  <= '0;
      terr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      terr_q <= terr_d;
    end
  end

  assign Timeout_err = terr_q;
`else
  // No watchdog: the arbiter waits on the adder indefinitely.
  assign tmo_hit     = (TIMEOUT < 0);
  assign Timeout_err = 1'b0;
`endif

  // Next-state and datapath decisions for the IDLE/ISSUE/RESP/RELEASE handshake.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    adv_d   = adv_q;
    ack_d   = ack_q;
    res_d   = res_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE: begin
        // Only start when the adder has finished its previous four-phase cycle.
        if (pick_any && !Adder_ack) begin
          grant_d = pick_gnt;
          gidx_d  = pick_idx;
          for (int p = 0; p < NREQ; p++) begin
            if (pick_gnt[p]) begin
              opa_d = Req_datain1[p*WIDTH +: WIDTH];
              opb_d = Req_datain2[p*WIDTH +: WIDTH];
            end
          end
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        adv_d = 1'b1;
        if (Adder_ack && adv_q) begin
          res_d   = Adder_dataout;
          cout_d  = Adder_carryout;
          adv_d   = 1'b0;
          // A requester that already withdrew gets no ack; its result is dropped.
          ack_d   = grant_q & Req_valid;
          state_d = RESP;
        end else if (tmo_hit) begin
          res_d   = '0;
          cout_d  = 1'b0;
          adv_d   = 1'b0;
          ack_d   = grant_q & Req_valid;
          state_d = RESP;
        end
      end

      RESP: begin
        if (!owner_vld) begin
          ack_d   = '0;
          state_d = RELEASE;
        end
      end

      RELEASE: begin
        if (!Adder_ack || tmo_hit) begin
          grant_d = '0;
          ptr_d   = next_ptr(gidx_q, NREQ);
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
        adv_d   = 1'b0;
        ack_d   = '0;
      end
    endcase
  end

  // State and datapath registers; reset kills any in-flight handshake at once.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      adv_q   <= 1'b0;
      ack_q   <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      adv_q   <= adv_d;
      ack_q   <= ack_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
    end
  end

  assign Grant         = grant_q;
  assign Req_ack       = ack_q;
  assign Req_dataout   = res_q;
  assign Req_carryout  = cout_q;
  assign Adder_valid   = adv_q;
  assign Adder_datain1 = opa_q;
  assign Adder_datain2 = opb_q;
  assign Busy          = (state_q != IDLE);

endmodule

// File: tb/tb_fpu_adder_arbiter.sv
// Directed bench for fpu_adder_arbiter with a four-phase adder model and result scoreboard.
// Latency: adder model acks three cycles after it sees REQ.
// Backpressure: requesters hold valid until ack, then release.
module tb_fpu_adder_arbiter;

  localparam int W = 25;
  localparam int N = 2;

  logic            CLK;
  logic            RST;
  logic [N-1:0]    Req_valid;
  logic [N*W-1:0]  Req_datain1;
  logic [N*W-1:0]  Req_datain2;
  logic [N-1:0]    Req_ack;
  logic [W-1:0]    Req_dataout;
  logic            Req_carryout;
  logic [N-1:0]    Grant;
  logic            Busy;
  logic [W-1:0]    Adder_datain1;
  logic [W-1:0]    Adder_datain2;
  logic            Adder_valid;
  logic [W-1:0]    Adder_dataout;
  logic            Adder_carryout;
  logic            Adder_ack;
  logic            Timeout_err;

  logic            ack_en;
  logic [1:0]      mcnt;
  int              total = 0;
  int              bad = 0;
  int              overlap = 0;

  typedef struct {
    logic [N-1:0] gnt;
    logic [W-1:0] sum;
    logic         cout;
  } exp_t;

  exp_t expq[$];

  fpu_adder_arbiter #(.WIDTH(W), .NREQ(N), .TIMEOUT(8)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .Req_valid      (Req_valid),
    .Req_datain1    (Req_datain1),
    .Req_datain2    (Req_datain2),
    .Req_ack        (Req_ack),
    .Req_dataout    (Req_dataout),
    .Req_carryout   (Req_carryout),
    .Grant          (Grant),
    .Busy           (Busy),
    .Adder_datain1  (Adder_datain1),
    .Adder_datain2  (Adder_datain2),
    .Adder_valid    (Adder_valid),
    .Adder_dataout  (Adder_dataout),
    .Adder_carryout (Adder_carryout),
    .Adder_ack      (Adder_ack),
    .Timeout_err    (Timeout_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Four-phase adder: ack after a short delay with the sum, drop ack once REQ falls.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Adder_ack      <= 1'b0;
      Adder_dataout  <= '0;
      Adder_carryout <= 1'b0;
      mcnt           <= '0;
    end else if (Adder_valid && !Adder_ack && ack_en) begin
      if (mcnt == 2'd2) begin
        Adder_ack                       <= 1'b1;
        {Adder_carryout, Adder_dataout} <= {1'b0, Adder_datain1} + {1'b0, Adder_datain2};
        mcnt                            <= '0;
      end else begin
        mcnt <= mcnt + 2'd1;
      end
    end else if (!Adder_valid && Adder_ack) begin
      Adder_ack <= 1'b0;
    end
  end

  // REQ to the adder and an ack to a requester must never coexist.
  always @(negedge CLK) begin
    if (Adder_valid && (|Req_ack)) overlap++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_valid(input int i, input logic v);
    if (i == 0) Req_valid[0] = v;
    else        Req_valid[1] = v;
  endtask

  task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    if (i == 0) begin
      Req_datain1[W-1:0] = a;
      Req_datain2[W-1:0] = b;
    end else begin
      Req_datain1[2*W-1:W] = a;
      Req_datain2[2*W-1:W] = b;
    end
    set_valid(i, 1'b1);
  endtask

  task automatic push_exp(input int i, input logic [W-1:0] s, input logic c);
    exp_t e;
    e.gnt  = (i == 0) ? 2'b01 : 2'b10;
    e.sum  = s;
    e.cout = c;
    expq.push_back(e);
  endtask

  task automatic issue_add(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] full;
    full = {1'b0, a} + {1'b0, b};
    issue(i, a, b);
    push_exp(i, full[W-1:0], full[W]);
  endtask

  // Wait for one completion, score it, release the owner and optionally re-request.
  task automatic serve(input string tag, input bit again, input logic [W-1:0] na, input logic [W-1:0] nb);
    exp_t e;
    int   n;
    int   i;
    n = 0;
    while (Req_ack == '0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (Req_ack == '0) begin
      total++;
      bad++;
      $error("FAIL %s_wait: Req_ack observed=0 expected=nonzero within 100 cycles", tag);
      return;
    end
    if (expq.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_queue: observed ack=%0h expected=no completion", tag, Req_ack);
      return;
    end
    e = expq.pop_front();
    chk({tag, "_ack"},   32'(Req_ack),      32'(e.gnt));
    chk({tag, "_grant"}, 32'(Grant),        32'(e.gnt));
    chk({tag, "_sum"},   32'(Req_dataout),  32'(e.sum));
    chk({tag, "_cout"},  32'(Req_carryout), 32'(e.cout));
    i = e.gnt[1] ? 1 : 0;
    set_valid(i, 1'b0);
    n = 0;
    while (Req_ack != '0 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, "_ackdrop"}, 32'(Req_ack), 32'd0);
    if (again) issue_add(i, na, nb);
  endtask

  initial begin
    int  n;
    bit  saw_ack;

    RST         = 1'b1;
    Req_valid   = '0;
    Req_datain1 = '0;
    Req_datain2 = '0;
    ack_en      = 1'b1;
    repeat (3) @(negedge CLK);

    // Reset state
    chk("rst_grant",  32'(Grant),       32'd0);
    chk("rst_busy",   32'(Busy),        32'd0);
    chk("rst_avalid", 32'(Adder_valid), 32'd0);
    chk("rst_ack",    32'(Req_ack),     32'd0);
    chk("rst_terr",   32'(Timeout_err), 32'd0);
    RST = 1'b0;
    @(negedge CLK);

    // T1: single add, arbitration latency and operand latching
    issue_add(0, 25'h0000003, 25'h0000005);
    @(negedge CLK);
    chk("t1_grant",   32'(Grant),       32'h1);
    chk("t1_busy",    32'(Busy),        32'd1);
    chk("t1_avalid0", 32'(Adder_valid), 32'd0);
    Req_datain1[W-1:0] = 25'h1234567;
    @(negedge CLK);
    chk("t1_avalid1", 32'(Adder_valid), 32'd1);
    chk("t1_opa",     32'(Adder_datain1), 32'd3);
    chk("t1_opb",     32'(Adder_datain2), 32'd5);
    serve("t1", 1'b0, '0, '0);

    // T2: carry out of the top bit
    issue_add(1, 25'h1FFFFFF, 25'h0000001);
    serve("t2", 1'b0, '0, '0);

    // T3: simultaneous requests twice, pointer at 0 each time
    issue_add(0, 25'd10, 25'd20);
    issue_add(1, 25'd100, 25'd200);
    serve("t3a", 1'b0, '0, '0);
    serve("t3b", 1'b0, '0, '0);
    issue_add(0, 25'h0FFFFFF, 25'h0FFFFFF);
    issue_add(1, 25'h1000000, 25'h1000000);
    serve("t3c", 1'b0, '0, '0);
    serve("t3d", 1'b0, '0, '0);

    // T4: immediate re-requests alternate 0,1,0,1
    issue_add(0, 25'd1, 25'd2);
    issue_add(1, 25'd3, 25'd4);
    serve("t4a", 1'b1, 25'd5, 25'd6);
    serve("t4b", 1'b1, 25'd7, 25'd8);
    serve("t4c", 1'b0, '0, '0);
    serve("t4d", 1'b0, '0, '0);

    // Withdraw before ack: no Req_ack, pointer still advances past req0
    issue(0, 25'd50, 25'd60);
    n = 0;
    while (Grant != 2'b01 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("abort_grant", 32'(Grant), 32'h1);
    set_valid(0, 1'b0);
    saw_ack = 1'b0;
    n = 0;
    while (Busy && n < 50) begin
      @(negedge CLK);
      if (Req_ack != '0) saw_ack = 1'b1;
      n++;
    end
    chk("abort_noack", 32'(saw_ack), 32'd0);
    chk("abort_idle",  32'(Busy),    32'd0);
    issue_add(1, 25'd11, 25'd22);
    issue_add(0, 25'd33, 25'd44);
    serve("abort_r1", 1'b0, '0, '0);
    serve("abort_r0", 1'b0, '0, '0);

    // T5: reset while Adder_valid is high; pointer returns to 0
    issue(1, 25'd9, 25'd9);
    n = 0;
    while (!Adder_valid && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("t5_avalid_pre", 32'(Adder_valid), 32'd1);
    RST = 1'b1;
    #1;
    chk("t5_avalid", 32'(Adder_valid), 32'd0);
    chk("t5_grant",  32'(Grant),       32'd0);
    chk("t5_busy",   32'(Busy),        32'd0);
    chk("t5_ack",    32'(Req_ack),     32'd0);
    Req_valid = '0;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    issue_add(0, 25'd1000, 25'd2000);
    issue_add(1, 25'h1555555, 25'h0AAAAAB);
    serve("t5a", 1'b0, '0, '0);
    serve("t5b", 1'b0, '0, '0);

`ifdef ADDER_ARB_TIMEOUT_EN
    // T6: adder never acks; watchdog completes with zero result and sticky error
    ack_en = 1'b0;
    issue(0, 25'd7, 25'd9);
    push_exp(0, '0, 1'b0);
    serve("t6", 1'b0, '0, '0);
    chk("t6_terr", 32'(Timeout_err), 32'd1);
    ack_en = 1'b1;
    repeat (4) @(negedge CLK);
    chk("t6_terr_sticky", 32'(Timeout_err), 32'd1);
`else
    chk("terr_tied", 32'(Timeout_err), 32'd0);
`endif

    repeat (4) @(negedge CLK);
    chk("end_idle",    32'(Busy),        32'd0);
    chk("no_overlap",  32'(overlap),     32'd0);
    chk("queue_empty", 32'(expq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound in case a handshake loop misbehaves.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
